// File: rtl/apb_arbiter_if.sv
// apb_arbiter_if
// Bundles the local requester handshake and the shared APB completer port
// used by apb_arbiter.
//
// Parameters: NREQ (requesters), AW (address width), DW (data width).
//
// Signals:
//   req, rq_write, rq_addr, rq_wdata  per-requester request fields (packed, requester i at [i*W +: W])
//   done, rsp_rdata, rsp_err          completion strobe and response returned to the owner
//   gnt                               one-hot current owner
//   pselx, penable, pwrite, paddr, pwdata   APB request side
//   prdata, pready, pslverr                 APB response side
//
// Modports:
//   master  the arbiter side (drives APB and the requester responses)
//   slave   the environment side (requesters plus completer)
interface apb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    rq_write;
  logic [NREQ*AW-1:0] rq_addr;
  logic [NREQ*DW-1:0] rq_wdata;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [NREQ-1:0]    gnt;
  logic               pselx;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    input  req, rq_write, rq_addr, rq_wdata, prdata, pready, pslverr,
    output done, rsp_rdata, rsp_err, gnt, pselx, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req, rq_write, rq_addr, rq_wdata, prdata, pready, pslverr,
    input  done, rsp_rdata, rsp_err, gnt, pselx, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_arbiter.sv
// apb_arbiter
// Shares one APB completer port among NREQ local requesters. Arbitration is
// round-robin; the FSM walks IDLE -> SETUP -> ACCESS and waits for pready.
// On completion the read data and slave error are returned to the owner,
// and a pending request from another requester is chained straight into a
// new SETUP phase without passing through IDLE.
//
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS phase. After
// TIMEOUT wait cycles without pready the transfer is forced to complete
// with rsp_err = 1 and rsp_rdata = 0.
//
// Ports:
//   pclk     clock, rising edge
//   presetn  synchronous active-low reset
//   bus      apb_arbiter_if.master (requester fields, responses, APB port)
module apb_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  apb_arbiter_if.master bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;

  logic [IDXW-1:0]   arbPtr;
  logic [NREQ-1:0]   arbReq;
  logic              winFound;
  logic [IDXW-1:0]   winIdx;
  logic [NREQ-1:0]   winOneHot;
  int                cand;

  logic              timeoutHit;
  logic              complete;

`ifdef APB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0]   waitCnt_q, waitCnt_d;

  // The cycle that would make the count reach TIMEOUT is itself the
  // forced-completion cycle, so the 4th wait cycle ends a TIMEOUT=4 access.
  assign timeoutHit = (state_q == ACCESS) && !bus.pready &&
                      (waitCnt_q == CNTW'(TIMEOUT - 1));

  // SETUP always precedes ACCESS, so clearing there clears on ACCESS entry.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_q == SETUP) begin
      waitCnt_d = '0;
    end else if ((state_q == ACCESS) && !bus.pready && !timeoutHit) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  assign complete = (state_q == ACCESS) && (bus.pready || timeoutHit);

  // In the completion cycle the current owner is masked out and the scan
  // starts just after it, which is what keeps back-to-back grants fair.
  always_comb begin
    arbPtr   = last_q;
    arbReq   = bus.req;
    winFound = 1'b0;
    winIdx   = '0;
    cand     = 0;
    if (state_q == ACCESS) begin
      arbPtr = owner_q;
      arbReq = bus.req & ~gnt_q;
    end
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(arbPtr) + k) % NREQ;
      if (!winFound && arbReq[cand]) begin
        winFound = 1'b1;
        winIdx   = IDXW'(cand);
      end
    end
    winOneHot = {{(NREQ-1){1'b0}}, 1'b1} << winIdx;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    unique case (state_q)
      IDLE: begin
        if (winFound) begin
          state_d  = SETUP;
          gnt_d    = winOneHot;
          owner_d  = winIdx;
          paddr_d  = bus.rq_addr[winIdx*AW +: AW];
          pwdata_d = bus.rq_wdata[winIdx*DW +: DW];
          pwrite_d = bus.rq_write[winIdx];
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (complete) begin
          last_d = owner_q;
          if (winFound) begin
            state_d  = SETUP;
            gnt_d    = winOneHot;
            owner_d  = winIdx;
            paddr_d  = bus.rq_addr[winIdx*AW +: AW];
            pwdata_d = bus.rq_wdata[winIdx*DW +: DW];
            pwrite_d = bus.rq_write[winIdx];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Reset mid-transfer simply drops back to IDLE; because done is decoded
  // from state, the aborted transfer never produces a completion strobe.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      last_q   <= IDXW'(NREQ - 1);
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  assign bus.pselx     = (state_q != IDLE);
  assign bus.penable   = (state_q == ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.gnt       = gnt_q;
  assign bus.done      = complete ? gnt_q : '0;
  assign bus.rsp_err   = complete && (bus.pready ? bus.pslverr : 1'b1);
  assign bus.rsp_rdata = timeoutHit ? '0 : bus.prdata;

endmodule
